mac_reg_bus_master: RTL

- Sequencing master for the MAC CPU register bus (CSB/WRB/CA/CD, 16-bit data, register index = CA[7:1]).
- Shares that bus between an external host requester and an internal init sequencer.
- After reset (or on Start), the sequencer loads a 48-bit station address into the TX and RX address PROMs through the PROM data/addr/wr registers, then enables TX address insertion and RX address check.
- Sits between the host interface logic and the register file. Its bus outputs drive the register file's CSB/WRB/CA/CD_in, and it reads back the register file's CD_out.

---
 rtl/mac_reg_bus_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_reg_bus_master.sv
// mac_reg_bus_master
//   Master for the MAC CPU register bus (CSB/WRB/CA/CD). Two requesters share the
//   bus: the external host and an internal init sequencer. The sequencer loads
//   the 48-bit station address into the TX (and optionally RX) address PROMs,
//   then enables TX address insertion and RX address check.
//   Every bus transaction takes three cycles: IDLE (arbitrate) -> ISSUE -> COMPLETE.
// Ports
//   Reset, Clk_reg        : async active-high reset, bus clock (posedge)
//   Start, MAC_addr       : start pulse and station address (latched at start)
//   Busy, Done            : sequencer active / sequence finished
//   H_req/H_wr/H_addr/H_wdata, H_ack/H_rdata : host request/response
//   CSB, WRB, CA, CD_wr   : bus outputs to register file; CD_rd : read data back
module mac_reg_bus_master #(
  parameter bit AUTO_START = 1'b1,
  parameter bit LOAD_RX    = 1'b1
) (
  input  logic        Reset,
  input  logic        Clk_reg,
  input  logic        Start,
  input  logic [47:0] MAC_addr,
  output logic        Busy,
  output logic        Done,
  input  logic        H_req,
  input  logic        H_wr,
  input  logic [7:0]  H_addr,
  input  logic [15:0] H_wdata,
  output logic        H_ack,
  output logic [15:0] H_rdata,
  output logic        CSB,
  output logic        WRB,
  output logic [7:0]  CA,
  output logic [15:0] CD_wr,
  input  logic [15:0] CD_rd
);

  localparam int         NSTEPS = LOAD_RX ? 50 : 25;
  localparam logic [5:0] LAST   = 6'(NSTEPS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

  state_t      state_q, state_d;
  logic        rr_host_q, rr_host_d;    // last grant went to host (0 = seq)
  logic        own_host_q, own_host_d;  // current transaction belongs to host
  logic        wr_q, wr_d;              // current transaction is a write
  logic        auto_q, auto_d;          // one-shot start right after reset
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  step_q, step_d;
  logic [47:0] mac_q, mac_d;
  logic        csb_q, csb_d;
  logic        wrb_q, wrb_d;
  logic [7:0]  ca_q, ca_d;
  logic [15:0] cd_q, cd_d;
  logic        ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;

  // Step decoder: steps are grouped 4 per PROM byte (data, addr, wr=1, wr=0),
  // TX PROM first, then RX PROM, then the two enable writes.
  logic [7:0]  s_ca, base, bsel;
  logic [15:0] s_cd;
  logic [4:0]  t;
  logic [2:0]  bi;

  always_comb begin
    s_ca = 8'h0E;
    s_cd = 16'h0001;
    base = 8'h10;
    t    = step_q[4:0];
    if (LOAD_RX && step_q >= 6'd24) begin
      t    = 5'(step_q - 6'd24);
      base = 8'h1E;
    end
    bi = t[4:2];
    case (bi)
      3'd0:    bsel = mac_q[47:40];
      3'd1:    bsel = mac_q[39:32];
      3'd2:    bsel = mac_q[31:24];
      3'd3:    bsel = mac_q[23:16];
      3'd4:    bsel = mac_q[15:8];
      default: bsel = mac_q[7:0];
    endcase
    if (step_q < 6'd24 || (LOAD_RX && step_q < 6'd48)) begin
      case (t[1:0])
        2'd0:    begin s_ca = base;         s_cd = {8'h00, bsel}; end
        2'd1:    begin s_ca = base + 8'd2;  s_cd = {13'd0, bi};   end
        2'd2:    begin s_ca = base + 8'd4;  s_cd = 16'h0001;      end
        default: begin s_ca = base + 8'd4;  s_cd = 16'h0000;      end
      endcase
    end else if (LOAD_RX && step_q == LAST) begin
      s_ca = 8'h1C;
    end
  end

  logic host_rq, seq_rq, gnt_host, start_go;

  always_comb begin
    state_d    = state_q;
    rr_host_d  = rr_host_q;
    own_host_d = own_host_q;
    wr_d       = wr_q;
    auto_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    step_d     = step_q;
    mac_d      = mac_q;
    csb_d      = csb_q;
    wrb_d      = wrb_q;
    ca_d       = ca_q;
    cd_d       = cd_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    // Host is masked during its own ack cycle so a held H_req is not re-served.
    host_rq    = H_req && !ack_q;
    seq_rq     = busy_q;
    gnt_host   = host_rq && (!seq_rq || !rr_host_q);
    // A start can never coincide with a seq COMPLETE: that needs busy_q high.
    start_go   = (Start || auto_q) && !busy_q;

    if (start_go) begin
      mac_d  = MAC_addr;
      busy_d = 1'b1;
      done_d = 1'b0;
      step_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (host_rq || seq_rq) begin
          own_host_d = gnt_host;
          rr_host_d  = gnt_host;
          wr_d       = gnt_host ? H_wr    : 1'b1;
          ca_d       = gnt_host ? H_addr  : s_ca;
          cd_d       = gnt_host ? H_wdata : s_cd;
          csb_d      = 1'b0;
          wrb_d      = gnt_host ? !H_wr : 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        csb_d   = 1'b1;
        wrb_d   = 1'b1;
        state_d = COMPLETE;
      end
      COMPLETE: begin
        state_d = IDLE;
        if (own_host_q) begin
          ack_d = 1'b1;
          if (!wr_q) rdata_d = CD_rd;
        end else if (step_q == LAST) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          step_d = step_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      rr_host_q  <= 1'b0;
      own_host_q <= 1'b0;
      wr_q       <= 1'b0;
      auto_q     <= AUTO_START;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= '0;
      mac_q      <= '0;
      csb_q      <= 1'b1;
      wrb_q      <= 1'b1;
      ca_q       <= '0;
      cd_q       <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_host_q  <= rr_host_d;
      own_host_q <= own_host_d;
      wr_q       <= wr_d;
      auto_q     <= auto_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_q     <= step_d;
      mac_q      <= mac_d;
      csb_q      <= csb_d;
      wrb_q      <= wrb_d;
      ca_q       <= ca_d;
      cd_q       <= cd_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign H_ack   = ack_q;
  assign H_rdata = rdata_q;
  assign CSB     = csb_q;
  assign WRB     = wrb_q;
  assign CA      = ca_q;
  assign CD_wr   = cd_q;

endmodule
